// File: rtl/uart_frame_decoder.sv
// -----------------------------------------------------------------------------
// uart_frame_decoder
//   Assembles 5-byte controller frames (SYNC, CMD, D0, D1, CHK) from a UART
//   receiver byte stream. It verifies the XOR checksum CHK == CMD ^ D0 ^ D1 and
//   publishes CMD/DATA with a one-cycle strobe. Bad frames raise a one-cycle
//   error strobe and bump a saturating error counter.
//
// Optional feature macro: FRAME_DECODER_TIMEOUT_EN
//   Defined   : an inter-byte timeout drops a partial frame and flags an error.
//   Undefined : a partial frame waits indefinitely for its next byte.
//
// Ports
//   i_CLK          in   1   system clock
//   i_RST          in   1   asynchronous reset, active-high
//   i_RX_DV        in   1   byte valid strobe from the UART receiver
//   i_RX_BYTE      in   8   received byte, qualified by i_RX_DV
//   o_FRAME_VALID  out  1   1-cycle pulse, good frame (o_CMD/o_DATA updated)
//   o_FRAME_ERR    out  1   1-cycle pulse, checksum mismatch or timeout
//   o_CMD          out  8   command byte of the last good frame
//   o_DATA         out  16  {D0,D1} of the last good frame
//   o_ERR_COUNT    out  8   saturating count of error pulses
//   o_BUSY         out  1   high while a frame is partially received
// -----------------------------------------------------------------------------
module uart_frame_decoder #(
  parameter logic [7:0]  c_SYNC_BYTE      = 8'hA5,
  parameter int unsigned c_TIMEOUT_CYCLES = 4340
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_RX_DV,
  input  logic [7:0]  i_RX_BYTE,
  output logic        o_FRAME_VALID,
  output logic        o_FRAME_ERR,
  output logic [7:0]  o_CMD,
  output logic [15:0] o_DATA,
  output logic [7:0]  o_ERR_COUNT,
  output logic        o_BUSY
);

  typedef enum logic [2:0] {
    s_IDLE,
    s_CMD,
    s_D0,
    s_D1,
    s_CHK
  } t_state;

  // The timeout counter is 16 bits wide, so the programmed window must fit.
  if (c_TIMEOUT_CYCLES == 0 || c_TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("uart_frame_decoder: c_TIMEOUT_CYCLES must be in 1..65535");
  end

  t_state      r_state;
  logic [7:0]  r_acc;
  logic [7:0]  r_cmd_tmp;
  logic [7:0]  r_d0;
  logic [7:0]  r_d1;
  logic        r_frame_valid;
  logic        r_frame_err;
  logic [7:0]  r_cmd;
  logic [15:0] r_data;
  logic [7:0]  r_err_count;
  logic        r_busy;

`ifdef FRAME_DECODER_TIMEOUT_EN
  localparam logic [15:0] c_TO_LAST = 16'(c_TIMEOUT_CYCLES - 1);
  logic [15:0] r_to_cnt;
`endif

  // Frame FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state       <= s_IDLE;
      r_acc         <= 8'h00;
      r_cmd_tmp     <= 8'h00;
      r_d0          <= 8'h00;
      r_d1          <= 8'h00;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_cmd         <= 8'h00;
      r_data        <= 16'h0000;
      r_err_count   <= 8'h00;
      r_busy        <= 1'b0;
`ifdef FRAME_DECODER_TIMEOUT_EN
      r_to_cnt      <= 16'h0000;
`endif
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;

      if (i_RX_DV) begin
        case (r_state)
          s_IDLE: begin
            // Anything other than SYNC between frames is line noise.
            if (i_RX_BYTE == c_SYNC_BYTE) begin
              r_acc   <= 8'h00;
              r_state <= s_CMD;
              r_busy  <= 1'b1;
            end
          end
          s_CMD: begin
            r_cmd_tmp <= i_RX_BYTE;
            r_acc     <= i_RX_BYTE;
            r_state   <= s_D0;
          end
          s_D0: begin
            r_d0    <= i_RX_BYTE;
            r_acc   <= r_acc ^ i_RX_BYTE;
            r_state <= s_D1;
          end
          s_D1: begin
            r_d1    <= i_RX_BYTE;
            r_acc   <= r_acc ^ i_RX_BYTE;
            r_state <= s_CHK;
          end
          s_CHK: begin
            r_state <= s_IDLE;
            r_busy  <= 1'b0;
            if (i_RX_BYTE == r_acc) begin
              r_cmd         <= r_cmd_tmp;
              r_data        <= {r_d0, r_d1};
              r_frame_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
              if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
              end
            end
          end
          default: begin
            r_state <= s_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end

`ifdef FRAME_DECODER_TIMEOUT_EN
      // A byte arriving on the expiry cycle restarts the window instead of timing out.
      if (i_RX_DV || r_state == s_IDLE) begin
        r_to_cnt <= 16'h0000;
      end else if (r_to_cnt == c_TO_LAST) begin
        r_to_cnt    <= 16'h0000;
        r_state     <= s_IDLE;
        r_busy      <= 1'b0;
        r_frame_err <= 1'b1;
        if (r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end else begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end
`endif
    end
  end

  assign o_FRAME_VALID = r_frame_valid;
  assign o_FRAME_ERR   = r_frame_err;
  assign o_CMD         = r_cmd;
  assign o_DATA        = r_data;
  assign o_ERR_COUNT   = r_err_count;
  assign o_BUSY        = r_busy;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_decoder
//   Directed self-checking bench for uart_frame_decoder. Builds with or without
//   FRAME_DECODER_TIMEOUT_EN; the DUT timeout is set to 100 cycles.
// -----------------------------------------------------------------------------
module tb_uart_frame_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        frame_valid;
  logic        frame_err;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic [7:0]  err_count;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_err   = 0;
  int n_both  = 0;

  always #5 clk = ~clk;

  uart_frame_decoder #(
    .c_SYNC_BYTE      (8'hA5),
    .c_TIMEOUT_CYCLES (100)
  ) dut (
    .i_CLK         (clk),
    .i_RST         (rst),
    .i_RX_DV       (rx_dv),
    .i_RX_BYTE     (rx_byte),
    .o_FRAME_VALID (frame_valid),
    .o_FRAME_ERR   (frame_err),
    .o_CMD         (cmd),
    .o_DATA        (data),
    .o_ERR_COUNT   (err_count),
    .o_BUSY        (busy)
  );

  // Pulse monitor: a strobe wider than one cycle is counted more than once.
  always @(negedge clk) begin
    if (frame_valid) n_valid++;
    if (frame_err) n_err++;
    if (frame_valid && frame_err) n_both++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    rx_dv = 1'b0;
    idle(2);
    n_tests++;
    if ({frame_valid, frame_err, cmd, data, err_count, busy} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b e=%b cmd=%h data=%h cnt=%h busy=%b, want all 0",
               frame_valid, frame_err, cmd, data, err_count, busy);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_good_frame;
    int v0 = n_valid;
    int e0 = n_err;
    send(8'hA5); send(8'h01); send(8'h12); send(8'h34);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL good_busy_mid: got %b want 1", busy);
    end
    @(negedge clk);
    rx_dv = 1'b1; rx_byte = 8'h27;
    @(posedge clk); #1;
    n_tests++;
    if ({frame_valid, frame_err, busy} !== 3'b100) begin
      n_fail++; $display("FAIL good_latency: got v/e/busy=%b want 100", {frame_valid, frame_err, busy});
    end
    @(negedge clk); rx_dv = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL good_pulse_width: got %b want 0", frame_valid);
    end
    idle(2);
    n_tests++;
    if ((n_valid - v0) != 1 || (n_err - e0) != 0) begin
      n_fail++; $display("FAIL good_pulses: got valid=%0d err=%0d want 1/0", n_valid - v0, n_err - e0);
    end
    n_tests++;
    if (cmd !== 8'h01 || data !== 16'h1234) begin
      n_fail++; $display("FAIL good_payload: got cmd=%h data=%h want 01/1234", cmd, data);
    end
    n_tests++;
    if (err_count !== 8'h00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL good_cnt_busy: got cnt=%h busy=%b want 00/0", err_count, busy);
    end
  endtask

  task automatic test_bad_checksum;
    int v0 = n_valid;
    int e0 = n_err;
    send(8'hA5); send(8'h01); send(8'h12); send(8'h34); send(8'h28);
    idle(2);
    n_tests++;
    if ((n_valid - v0) != 0 || (n_err - e0) != 1) begin
      n_fail++; $display("FAIL bad_pulses: got valid=%0d err=%0d want 0/1", n_valid - v0, n_err - e0);
    end
    n_tests++;
    if (cmd !== 8'h01 || data !== 16'h1234) begin
      n_fail++; $display("FAIL bad_payload_kept: got cmd=%h data=%h want 01/1234", cmd, data);
    end
    n_tests++;
    if (err_count !== 8'h01) begin
      n_fail++; $display("FAIL bad_err_count: got %h want 01", err_count);
    end
  endtask

  task automatic test_junk_and_inner_sync;
    int v0 = n_valid;
    send(8'h00); send(8'hFF); send(8'h5A);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL junk_busy: got %b want 0", busy);
    end
    send(8'hA5); send(8'h7F); send(8'hA5); send(8'h00); send(8'hDA);
    idle(2);
    n_tests++;
    if ((n_valid - v0) != 1 || cmd !== 8'h7F || data !== 16'hA500) begin
      n_fail++; $display("FAIL inner_sync: got pulses=%0d cmd=%h data=%h want 1/7F/A500",
                         n_valid - v0, cmd, data);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq [10] = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h04,
                             8'hA5, 8'h03, 8'h00, 8'h01, 8'h02};
    logic [7:0] one [5] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h02};
    int v0 = n_valid;
    int e0 = n_err;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); rx_dv = 1'b1; rx_byte = one[i];
    end
    @(negedge clk); rx_dv = 1'b0;
    idle(2);
    n_tests++;
    if ((n_valid - v0) != 1 || cmd !== 8'h02 || data !== 16'h0000) begin
      n_fail++; $display("FAIL b2b_single: got pulses=%0d cmd=%h data=%h want 1/02/0000",
                         n_valid - v0, cmd, data);
    end
    v0 = n_valid;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rx_dv = 1'b1; rx_byte = seq[i];
    end
    @(negedge clk); rx_dv = 1'b0;
    idle(2);
    n_tests++;
    if ((n_valid - v0) != 2 || (n_err - e0) != 0 || cmd !== 8'h03 || data !== 16'h0001) begin
      n_fail++; $display("FAIL b2b_chain: got valid=%0d err=%0d cmd=%h data=%h want 2/0/03/0001",
                         n_valid - v0, n_err - e0, cmd, data);
    end
  endtask

  task automatic bad_frames(input int n);
    for (int f = 0; f < n; f++) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = (k == 0) ? 8'hA5 : ((k == 1) ? 8'h01 : 8'h00);
      end
    end
    @(negedge clk); rx_dv = 1'b0;
    idle(2);
  endtask

  task automatic test_saturation;
    int e0 = n_err;
    bad_frames(253);
    n_tests++;
    if (err_count !== 8'hFE || (n_err - e0) != 253) begin
      n_fail++; $display("FAIL sat_below: got cnt=%h pulses=%0d want FE/253", err_count, n_err - e0);
    end
    bad_frames(47);
    n_tests++;
    if (err_count !== 8'hFF || (n_err - e0) != 300) begin
      n_fail++; $display("FAIL sat_hold: got cnt=%h pulses=%0d want FF/300", err_count, n_err - e0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    int e0;
    send(8'hA5); send(8'h01);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({frame_valid, frame_err, cmd, data, err_count, busy} !== 35'd0) begin
      n_fail++; $display("FAIL reset_mid: got cmd=%h data=%h cnt=%h busy=%b want all 0",
                         cmd, data, err_count, busy);
    end
    @(negedge clk); rst = 1'b0;
    v0 = n_valid; e0 = n_err;
    send(8'hA5); send(8'h01); send(8'h12); send(8'h34); send(8'h27);
    idle(2);
    n_tests++;
    if ((n_valid - v0) != 1 || (n_err - e0) != 0 || cmd !== 8'h01 || data !== 16'h1234 ||
        err_count !== 8'h00) begin
      n_fail++; $display("FAIL after_reset: got valid=%0d err=%0d cmd=%h data=%h cnt=%h want 1/0/01/1234/00",
                         n_valid - v0, n_err - e0, cmd, data, err_count);
    end
  endtask

  task automatic test_timeout;
    int e0;
    send(8'hA5); send(8'h01);
    e0 = n_err;
`ifdef FRAME_DECODER_TIMEOUT_EN
    // Byte lands exactly on the expiry cycle: it must be accepted.
    idle(98);
    send(8'h12);
    n_tests++;
    if ((n_err - e0) != 0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL to_byte_wins: got err=%0d busy=%b want 0/1", n_err - e0, busy);
    end
    idle(98);
    n_tests++;
    if ((n_err - e0) != 0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL to_early: got err=%0d busy=%b want 0/1", n_err - e0, busy);
    end
    idle(3);
    n_tests++;
    if ((n_err - e0) != 1 || busy !== 1'b0 || err_count !== 8'h01) begin
      n_fail++; $display("FAIL to_expire: got err=%0d busy=%b cnt=%h want 1/0/01",
                         n_err - e0, busy, err_count);
    end
`else
    idle(10000);
    n_tests++;
    if ((n_err - e0) != 0 || busy !== 1'b1 || err_count !== 8'h00) begin
      n_fail++; $display("FAIL no_timeout: got err=%0d busy=%b cnt=%h want 0/1/00",
                         n_err - e0, busy, err_count);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_bad_checksum;
    test_junk_and_inner_sync;
    test_back_to_back;
    test_saturation;
    test_reset_mid_frame;
    test_timeout;
    n_tests++;
    if (n_both != 0) begin
      n_fail++; $display("FAIL strobe_overlap: got %0d overlapping cycles want 0", n_both);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
